grid_step_sequencer: RTL
========================

# grid_step_sequencer

Control and readout stage directly upstream and downstream of the grid-cell register/ALU array. It issues the cell-array Reset, Load and Shift strobes for a run of N diffusion steps. Between strobes it holds a fixed settle window so the combinational neighbour ALUs can resolve. After the last step it streams every cell's current value out over a valid/ready port, one cell per handshake.

## Interface
Parameters:
- NR_CELLS, 16: cells in the array; must be ≥ 2.
- DATA_W, 8: cell value width.
- SETTLE_CYCLES, 2: cycles between Load/Shift and the next Shift; must be ≥ 1.
- STEP_W, 8: width of the step count.

Ports:
- Clk  in  1  single clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  run request; sampled only in IDLE.
- Steps  in  STEP_W  number of Shift steps; captured with Start.
- Busy  out  1  high from the cycle after accepted Start until Done.
- Done  out  1  one-cycle pulse when a run completes.
- Cell_Reset  out  1  one-cycle clear strobe to all cells.
- Cell_Load  out  1  one-cycle parallel-load strobe (cells take their VAL).
- Cell_Shift  out  1  one-cycle shift strobe (cells take their ALU result).
- Cell_Val  in  NR_CELLS*DATA_W  flattened cell NEW_VAL outputs; cell i at bits [i*DATA_W +: DATA_W].
- Out_Data  out  DATA_W  value of cell Out_Index.
- Out_Index  out  $clog2(NR_CELLS)  cell index being offered.
- Out_Valid  out  1  Out_Data valid.
- Out_Ready  in  1  consumer accepts.
- Out_Last  out  1  high with Out_Valid when Out_Index == NR_CELLS-1.
- Step_Count  out  STEP_W  steps completed in the current/last run.

## Operation
- States: IDLE, CLEAR, LOAD, SETTLE, SHIFT, DRAIN, DONE.
- IDLE:
  - Start=1 captures Steps into steps_q, clears Step_Count, and goes to CLEAR.
  - Start=0 stays in IDLE.
- CLEAR: Cell_Reset=1 for one cycle, then LOAD.
- LOAD: Cell_Load=1 for one cycle.
  - steps_q==0 goes to DRAIN.
  - Otherwise goes to SETTLE with settle counter = SETTLE_CYCLES-1.
- SETTLE: decrements the counter; at 0 goes to SHIFT.
- SHIFT: Cell_Shift=1 for one cycle and Step_Count increments.
  - If the new Step_Count == steps_q, go to DRAIN.
  - Otherwise reload the settle counter and go to SETTLE.
- DRAIN:
  - Out_Valid=1 and Out_Data = Cell_Val slice at Out_Index (combinational mux; cells are quiescent in DRAIN).
  - Out_Valid&&Out_Ready advances Out_Index.
  - Handshake with Out_Last goes to DONE and wraps Out_Index to 0.
  - Out_Valid never drops while waiting for Ready, and Out_Data is stable while Valid&&!Ready.
- DONE: Done=1 for one cycle, then IDLE.
- Strobe exclusivity: at most one of Cell_Reset/Cell_Load/Cell_Shift is high in any cycle.
- Ignored inputs:
  - Start outside IDLE is ignored.
  - Steps changes after capture have no effect.
- Step_Count holds its final value until the next accepted Start.

## Timing
- Reset (async assert, sync release): state=IDLE, all strobes, Busy, Done and Out_Valid = 0; Out_Index=0, Step_Count=0, counters 0.
- Start accepted at edge 0:
  - CLEAR in cycle 1 and LOAD in cycle 2.
  - k-th Shift in cycle 2 + k*(SETTLE_CYCLES+1).
  - First Out_Valid in the cycle after the last Shift.
  - With Steps==0, first Out_Valid is in cycle 3.
- Drain with Ready held high takes NR_CELLS cycles. Done follows the last handshake by one cycle, and Start is accepted again the cycle after Done.
- Reset_n low mid-run: all strobes drop immediately (async) and the run is abandoned; no Done.
- Steps at maximum (2^STEP_W-1): Step_Count reaches the maximum without wrap.

## Structure
- Shared package grid_pkg holds:
  - state enum gs_state_t;
  - DATA_W default and the cell-flattening index helper, both shared with the cell array.
- One natural sub-module, grid_readout_mux: Cell_Val + index → Out_Data, purely combinational.
- The FSM, settle counter and step counter stay in the top.

## Test plan
- Reset: hold Reset_n=0, then release → all outputs 0 and Out_Index=0; Start pulse → Busy=1 next cycle.
- Steps=0, SETTLE_CYCLES=2, NR_CELLS=4:
  - Start → Cell_Reset in cycle 1, Cell_Load in cycle 2, Out_Valid in cycle 3.
  - Ready=1 → indices 0..3, then Done at cycle 7; Cell_Shift never asserted.
- Steps=3, SETTLE_CYCLES=2:
  - Cell_Shift exactly in cycles 5, 8 and 11; Step_Count=3.
  - Drain with Cell_Val = {8'h40,8'h30,8'h20,8'h10} → Out_Data sequence 10,20,30,40 with Out_Last on 40.
- Backpressure: toggle Ready 1,0,0,1,… during DRAIN → Out_Data/Out_Index stable while stalled, no cell skipped or repeated, exactly NR_CELLS handshakes.
- Start pulses during SETTLE and DRAIN → ignored; a single Done; Step_Count unchanged by the extra pulses.
- Reset_n low during SETTLE of step 2 → strobes and Busy go 0 asynchronously, no Done; new Start after release runs the full sequence from CLEAR.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared definitions for the grid-cell array and its step sequencer.
package grid_pkg;

  localparam int GRID_DATA_W = 8;

  typedef enum logic [2:0] {
    GS_IDLE,
    GS_CLEAR,
    GS_LOAD,
    GS_SETTLE,
    GS_SHIFT,
    GS_DRAIN,
    GS_DONE
  } gs_state_t;

  // LSB position of cell idx inside the flattened cell-value bus.
  function automatic int cellLsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/grid_readout_mux.sv
// Selects one cell value out of the flattened cell-array bus.
module grid_readout_mux
  import grid_pkg::*;
#(
  parameter int NR_CELLS = 16,
  parameter int DATA_W   = GRID_DATA_W
) (
  input  logic [NR_CELLS*DATA_W-1:0]   cellVal,
  input  logic [$clog2(NR_CELLS)-1:0]  index,
  output logic [DATA_W-1:0]            data
);

  localparam int IDX_W = $clog2(NR_CELLS);

  always_comb begin
    data = '0;
    for (int i = 0; i < NR_CELLS; i++) begin
      if (index == IDX_W'(i)) data = cellVal[cellLsb(i, DATA_W) +: DATA_W];
    end
  end

endmodule

// File: rtl/grid_step_sequencer.sv
// Sequences Reset/Load/Shift strobes for a run of diffusion steps, then
// streams every cell value out over a valid/ready port.
module grid_step_sequencer
  import grid_pkg::*;
#(
  parameter int NR_CELLS      = 16,
  parameter int DATA_W        = GRID_DATA_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int STEP_W        = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Start,
  input  logic [STEP_W-1:0]             Steps,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Cell_Reset,
  output logic                          Cell_Load,
  output logic                          Cell_Shift,
  input  logic [NR_CELLS*DATA_W-1:0]    Cell_Val,
  output logic [DATA_W-1:0]             Out_Data,
  output logic [$clog2(NR_CELLS)-1:0]   Out_Index,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic                          Out_Last,
  output logic [STEP_W-1:0]             Step_Count
);

  localparam int IDX_W = $clog2(NR_CELLS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NR_CELLS - 1);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  gs_state_t         state;
  logic [STEP_W-1:0] stepsQ;
  logic [CNT_W-1:0]  settleCnt;
  logic [STEP_W-1:0] nextCount;
  logic              handshake;

  assign nextCount = Step_Count + STEP_W'(1);
  assign handshake = Out_Valid && Out_Ready;
  assign Out_Last  = Out_Valid && (Out_Index == LAST_IDX);

  grid_readout_mux #(
    .NR_CELLS (NR_CELLS),
    .DATA_W   (DATA_W)
  ) uReadoutMux (
    .cellVal (Cell_Val),
    .index   (Out_Index),
    .data    (Out_Data)
  );

  // Strobes, Busy, Done and Out_Valid are set on the edge entering their state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= GS_IDLE;
      stepsQ     <= '0;
      settleCnt  <= '0;
      Step_Count <= '0;
      Out_Index  <= '0;
      Out_Valid  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Cell_Reset <= 1'b0;
      Cell_Load  <= 1'b0;
      Cell_Shift <= 1'b0;
    end else begin
      Cell_Reset <= 1'b0;
      Cell_Load  <= 1'b0;
      Cell_Shift <= 1'b0;
      Done       <= 1'b0;
      case (state)
        GS_IDLE: begin
          if (Start) begin
            stepsQ     <= Steps;
            Step_Count <= '0;
            Cell_Reset <= 1'b1;
            Busy       <= 1'b1;
            state      <= GS_CLEAR;
          end
        end
        GS_CLEAR: begin
          Cell_Load <= 1'b1;
          state     <= GS_LOAD;
        end
        GS_LOAD: begin
          if (stepsQ == '0) begin
            Out_Valid <= 1'b1;
            state     <= GS_DRAIN;
          end else begin
            settleCnt <= SETTLE_RELOAD;
            state     <= GS_SETTLE;
          end
        end
        GS_SETTLE: begin
          if (settleCnt == '0) begin
            Cell_Shift <= 1'b1;
            state      <= GS_SHIFT;
          end else begin
            settleCnt <= settleCnt - CNT_W'(1);
          end
        end
        GS_SHIFT: begin
          Step_Count <= nextCount;
          if (nextCount == stepsQ) begin
            Out_Valid <= 1'b1;
            state     <= GS_DRAIN;
          end else begin
            settleCnt <= SETTLE_RELOAD;
            state     <= GS_SETTLE;
          end
        end
        GS_DRAIN: begin
          if (handshake) begin
            if (Out_Last) begin
              Out_Index <= '0;
              Out_Valid <= 1'b0;
              Busy      <= 1'b0;
              Done      <= 1'b1;
              state     <= GS_DONE;
            end else begin
              Out_Index <= Out_Index + IDX_W'(1);
            end
          end
        end
        GS_DONE: state <= GS_IDLE;
        default: state <= GS_IDLE;
      endcase
    end
  end

endmodule
